// File: rtl/dcache_load_align_if.sv
// Request/response/result bundle between the cache response path and the load aligner.
interface dcache_load_align_if #(
    parameter int unsigned TAG_W   = 7,
    parameter int unsigned RDATA_W = 64,
    parameter int unsigned OFF_W   = 3
);
    logic               req_fire_i;
    logic [TAG_W-1:0]   req_tag_i;
    logic [OFF_W-1:0]   req_offset_i;
    logic [1:0]         req_size_i;
    logic               req_signed_i;
    logic               req_need_data_i;
    logic               rsp_valid_i;
    logic [TAG_W-1:0]   rsp_tag_i;
    logic [RDATA_W-1:0] rsp_rdata_i;
    logic               kill_i;
    logic               out_valid_o;
    logic [TAG_W-1:0]   out_tag_o;
    logic [63:0]        out_data_o;
    logic               out_err_o;
    logic               dup_err_o;
    logic [TAG_W:0]     outstanding_o;

    modport slave (
        input  req_fire_i, req_tag_i, req_offset_i, req_size_i, req_signed_i, req_need_data_i,
        input  rsp_valid_i, rsp_tag_i, rsp_rdata_i, kill_i,
        output out_valid_o, out_tag_o, out_data_o, out_err_o, dup_err_o, outstanding_o
    );

    modport master (
        output req_fire_i, req_tag_i, req_offset_i, req_size_i, req_signed_i, req_need_data_i,
        output rsp_valid_i, rsp_tag_i, rsp_rdata_i, kill_i,
        input  out_valid_o, out_tag_o, out_data_o, out_err_o, dup_err_o, outstanding_o
    );
endinterface

// File: rtl/dcache_load_align.sv
// Per-tag load metadata table plus response alignment/extension; registered result to the core.
// Tracks outstanding tags and flags unexpected responses and duplicate issue.
module dcache_load_align #(
    parameter int unsigned TAG_W   = 7,
    parameter int unsigned RDATA_W = 64,
    parameter int unsigned OFF_W   = 3
) (
    input logic               clk_i,
    input logic               rstn_i,
    dcache_load_align_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** TAG_W;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_d;
    logic [OFF_W-1:0] r_off  [DEPTH];
    logic [1:0]       r_size [DEPTH];
    logic             r_sgn  [DEPTH];
    logic             r_need [DEPTH];

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    logic [63:0]      r_out_data;
    logic             r_out_err;
    logic             r_dup_err;
    logic [TAG_W:0]   r_outstanding;
    logic [TAG_W:0]   w_outstanding_d;

    logic             w_rsp_fire;
    logic             w_rsp_hit;
    logic             w_same_tag;
    logic             w_req_ok;
    logic             w_dup;

    logic [OFF_W-1:0]   w_m_off;
    logic [1:0]         w_m_size;
    logic               w_m_sgn;
    logic               w_m_need;
    logic [OFF_W-1:0]   w_eff_off;
    logic [RDATA_W-1:0] w_shifted;
    logic [63:0]        w_aligned;

    // A kill drops the same-cycle response but still lets the request in.
    assign w_rsp_fire = bus.rsp_valid_i & ~bus.kill_i;
    assign w_rsp_hit  = w_rsp_fire & r_pending[bus.rsp_tag_i];
    assign w_same_tag = (bus.rsp_tag_i == bus.req_tag_i);
    assign w_req_ok   = bus.req_fire_i &
                        (bus.kill_i | ~r_pending[bus.req_tag_i] | (w_rsp_hit & w_same_tag));
    assign w_dup      = bus.req_fire_i & ~w_req_ok;

    assign w_m_off  = r_off[bus.rsp_tag_i];
    assign w_m_size = r_size[bus.rsp_tag_i];
    assign w_m_sgn  = r_sgn[bus.rsp_tag_i];
    assign w_m_need = r_need[bus.rsp_tag_i];

    always_comb begin
        w_eff_off = w_m_off;
        unique case (w_m_size)
            2'd0: w_eff_off = w_m_off;
            2'd1: w_eff_off[0] = 1'b0;
            2'd2: w_eff_off[1:0] = 2'b00;
            2'd3: w_eff_off = '0;
        endcase
    end

    assign w_shifted = bus.rsp_rdata_i >> {w_eff_off, 3'b000};

    always_comb begin
        w_aligned = w_shifted[63:0];
        unique case (w_m_size)
            2'd0: w_aligned = {{56{w_m_sgn & w_shifted[7]}},  w_shifted[7:0]};
            2'd1: w_aligned = {{48{w_m_sgn & w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_aligned = {{32{w_m_sgn & w_shifted[31]}}, w_shifted[31:0]};
            2'd3: w_aligned = w_shifted[63:0];
        endcase
        if (!w_m_need) begin
            w_aligned = '0;
        end
    end

    // Clear (kill or consumed response) happens before the request sets its bit.
    always_comb begin
        w_pending_d = r_pending;
        if (bus.kill_i) begin
            w_pending_d = '0;
        end else if (w_rsp_hit) begin
            w_pending_d[bus.rsp_tag_i] = 1'b0;
        end
        if (w_req_ok) begin
            w_pending_d[bus.req_tag_i] = 1'b1;
        end
    end

    always_comb begin
        if (bus.kill_i) begin
            w_outstanding_d = (TAG_W + 1)'(bus.req_fire_i);
        end else begin
            w_outstanding_d = r_outstanding + (TAG_W + 1)'(w_req_ok) - (TAG_W + 1)'(w_rsp_hit);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_out_valid   <= 1'b0;
            r_out_err     <= 1'b0;
            r_dup_err     <= 1'b0;
            r_out_tag     <= '0;
            r_out_data    <= '0;
        end else begin
            r_pending     <= w_pending_d;
            r_outstanding <= w_outstanding_d;
            r_out_valid   <= w_rsp_fire;
            r_out_err     <= w_rsp_fire & ~w_rsp_hit;
            r_dup_err     <= w_dup;
            if (w_rsp_fire) begin
                r_out_tag  <= bus.rsp_tag_i;
                r_out_data <= w_rsp_hit ? w_aligned : 64'd0;
            end
        end
    end

    // Metadata is only meaningful while pending, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_req_ok) begin
            r_off[bus.req_tag_i]  <= bus.req_offset_i;
            r_size[bus.req_tag_i] <= bus.req_size_i;
            r_sgn[bus.req_tag_i]  <= bus.req_signed_i;
            r_need[bus.req_tag_i] <= bus.req_need_data_i;
        end
    end

    assign bus.out_valid_o   = r_out_valid;
    assign bus.out_tag_o     = r_out_tag;
    assign bus.out_data_o    = r_out_data;
    assign bus.out_err_o     = r_out_err;
    assign bus.dup_err_o     = r_dup_err;
    assign bus.outstanding_o = r_outstanding;
endmodule

// File: tb/tb_dcache_load_align.sv
// Scoreboard bench for dcache_load_align: directed scenarios then random traffic against a
// per-tag reference model.
module tb_dcache_load_align;
    localparam int TAG_W   = 7;
    localparam int RDATA_W = 64;
    localparam int OFF_W   = 3;
    localparam int DEPTH   = 2 ** TAG_W;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;
    always #5 clk_i = ~clk_i;

    dcache_load_align_if #(.TAG_W(TAG_W), .RDATA_W(RDATA_W), .OFF_W(OFF_W)) bus ();

    dcache_load_align #(.TAG_W(TAG_W), .RDATA_W(RDATA_W), .OFF_W(OFF_W)) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
        logic             err;
    } rsp_t;

    typedef struct {
        logic valid;
        logic dup;
        int   cnt;
    } cyc_t;

    rsp_t rsp_q[$];
    cyc_t cyc_q[$];

    bit m_pend [DEPTH];
    int m_off  [DEPTH];
    int m_size [DEPTH];
    bit m_sgn  [DEPTH];
    bit m_need [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load result from the rules: naturally aligned offset, byte shift, truncate, extend.
    function automatic logic [63:0] ref_align(input logic [63:0] rdata, input int off,
                                              input int size, input bit sgn, input bit need);
        longint unsigned v;
        longint unsigned span;
        int bytes;
        int eff;
        if (!need) return 64'd0;
        bytes = 1 << size;
        eff   = (off / bytes) * bytes;
        v     = rdata >> (eff * 8);
        if (size < 3) begin
            span = 64'd1 << (8 * bytes);
            v    = v % span;
            if (sgn && v >= span / 2) v = v - span;
        end
        return v;
    endfunction

    task automatic drive(input bit rq, input int tag, input int off, input int sz, input bit sg,
                         input bit nd, input bit rv, input int rtag, input logic [63:0] rdata,
                         input bit kl);
        rsp_t r;
        cyc_t c;
        bit   fire;
        bit   dup;
        int   cnt;
        @(negedge clk_i);
        bus.req_fire_i      = rq;
        bus.req_tag_i       = TAG_W'(tag);
        bus.req_offset_i    = OFF_W'(off);
        bus.req_size_i      = 2'(sz);
        bus.req_signed_i    = sg;
        bus.req_need_data_i = nd;
        bus.rsp_valid_i     = rv;
        bus.rsp_tag_i       = TAG_W'(rtag);
        bus.rsp_rdata_i     = rdata;
        bus.kill_i          = kl;
        fire = rv && !kl;
        if (fire) begin
            r.tag  = TAG_W'(rtag);
            r.err  = !m_pend[rtag];
            r.data = r.err ? 64'd0
                           : ref_align(rdata, m_off[rtag], m_size[rtag], m_sgn[rtag], m_need[rtag]);
            rsp_q.push_back(r);
        end
        if (kl) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (fire) begin
            m_pend[rtag] = 1'b0;
        end
        dup = rq && m_pend[tag];
        if (rq && !dup) begin
            m_pend[tag] = 1'b1;
            m_off[tag]  = off;
            m_size[tag] = sz;
            m_sgn[tag]  = sg;
            m_need[tag] = nd;
        end
        cnt = 0;
        foreach (m_pend[i]) cnt += int'(m_pend[i]);
        c.valid = fire;
        c.dup   = dup;
        c.cnt   = cnt;
        cyc_q.push_back(c);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 0);
    endtask

    task automatic req(input int tag, input int off, input int sz, input bit sg, input bit nd);
        drive(1, tag, off, sz, sg, nd, 0, 0, 64'd0, 0);
    endtask

    task automatic rsp(input int tag, input logic [63:0] rdata);
        drive(0, 0, 0, 0, 0, 0, 1, tag, rdata, 0);
    endtask

    task automatic drain();
        int budget;
        repeat (2) idle();
        budget = 50;
        while (cyc_q.size() > 0 && budget > 0) begin
            @(posedge clk_i);
            #2;
            budget--;
        end
        if (cyc_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d cycles still queued, expected 0", cyc_q.size());
            cyc_q.delete();
        end
    endtask

    // Monitor: one expected record per driven cycle; results popped when the DUT presents one.
    initial begin
        cyc_t c;
        rsp_t r;
        forever begin
            @(posedge clk_i);
            #1;
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("out_valid", 64'(bus.out_valid_o), 64'(c.valid));
                check("dup_err", 64'(bus.dup_err_o), 64'(c.dup));
                check("outstanding", 64'(bus.outstanding_o), 64'(c.cnt));
                if (bus.out_valid_o === 1'b1) begin
                    if (rsp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: tag 0x%0h, expected no result",
                                 bus.out_tag_o);
                    end else begin
                        r = rsp_q.pop_front();
                        check("out_tag", 64'(bus.out_tag_o), 64'(r.tag));
                        check("out_data", bus.out_data_o, r.data);
                        check("out_err", 64'(bus.out_err_o), 64'(r.err));
                    end
                end
            end
        end
    end

    initial begin
        bus.req_fire_i      = 1'b0;
        bus.req_tag_i       = '0;
        bus.req_offset_i    = '0;
        bus.req_size_i      = '0;
        bus.req_signed_i    = 1'b0;
        bus.req_need_data_i = 1'b0;
        bus.rsp_valid_i     = 1'b0;
        bus.rsp_tag_i       = '0;
        bus.rsp_rdata_i     = '0;
        bus.kill_i          = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_out_err", 64'(bus.out_err_o), 64'd0);
        check("rst_dup_err", 64'(bus.dup_err_o), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag_o), 64'd0);
        check("rst_out_data", bus.out_data_o, 64'd0);
        check("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Signed byte, unsigned word (plus misaligned offset), store, unexpected response.
        req(5, 3, 0, 1, 1);
        rsp(5, 64'h0000_0000_8000_0000);
        req(9, 4, 2, 0, 1);
        rsp(9, 64'hDEAD_BEEF_1234_5678);
        req(9, 6, 2, 0, 1);
        rsp(9, 64'hDEAD_BEEF_1234_5678);
        req(2, 0, 3, 0, 0);
        rsp(2, 64'hFFFF_FFFF_FFFF_FFFF);
        rsp(7, 64'h1234_5678_9ABC_DEF0);

        // Duplicate issue, then same-cycle response and request on the pending tag.
        req(3, 1, 1, 1, 1);
        req(3, 2, 0, 0, 1);
        drive(1, 3, 5, 0, 1, 1, 1, 3, 64'h0000_8000_0000_0000, 0);
        rsp(3, 64'h0000_8000_0000_0000);

        // Kill with concurrent request and response.
        req(1, 0, 3, 0, 1);
        req(11, 2, 1, 1, 1);
        req(12, 4, 2, 1, 1);
        drive(1, 13, 7, 0, 0, 1, 1, 12, 64'h8000_0000_0000_0000, 0);
        drive(1, 10, 2, 1, 1, 1, 1, 1, 64'hFFFF_0000_FFFF_0000, 1);
        idle();
        rsp(1, 64'h0123_4567_89AB_CDEF);
        rsp(10, 64'h0000_0000_8001_0000);
        drain();

        // Random traffic on a narrow tag range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)),
                  {$urandom(), $urandom()}, $urandom_range(0, 63) == 0);
        end
        drain();

        // Asynchronous reset in the middle of traffic.
        req(20, 0, 2, 1, 1);
        req(21, 4, 2, 1, 1);
        rsp(21, 64'hCAFE_F00D_0000_0001);
        drain();
        @(negedge clk_i);
        rstn_i = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("midrst_out_data", bus.out_data_o, 64'd0);
        check("midrst_out_tag", 64'(bus.out_tag_o), 64'd0);
        check("midrst_outstanding", 64'(bus.outstanding_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rsp(20, 64'h1111_2222_3333_4444);
        drain();

        check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
